// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with 3-sample majority vote.
// Reports framing/parity/overrun errors; words leave on valid/ready.
`timescale 1ns/1ps
module uart_rx_param #(
   parameter int CLK_PER_TICK = 54,
   parameter int OVERSAMPLE   = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun_err,
   output logic                 busy
);

   localparam int TW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);

   localparam logic [TW-1:0] TICK_LAST = TW'(CLK_PER_TICK - 1);
   localparam logic [SW-1:0] SMP_LAST  = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] SMP_A     = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] SMP_B     = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] SMP_C     = SW'(OVERSAMPLE / 2 + 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
   localparam logic          PAR_ODD   = (PARITY == 1);
   localparam logic          HAS_PAR   = (PARITY != 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP,
      S_WAIT
   } state_t;

   state_t state;
   state_t state_nxt;

   logic                 rx_meta;
   logic                 rxs;
   logic [TW-1:0]        tick_cnt;
   logic                 tick;
   logic [SW-1:0]        samp_cnt;
   logic                 s0;
   logic                 s1;
   logic                 vote;
   logic                 at_dec;
   logic                 at_wrap;
   logic                 cnt_clr;
   logic [BW-1:0]        bit_idx;
   logic                 stop_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 fe_int;
   logic                 pe_int;
   logic                 fe_fin;
   logic                 complete;

   assign tick    = (tick_cnt == TICK_LAST);
   assign at_dec  = tick && (samp_cnt == SMP_C);
   assign at_wrap = tick && (samp_cnt == SMP_LAST);
   assign vote    = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
   assign fe_fin  = fe_int | ~vote;
   assign busy    = (state != S_IDLE);

   // Counters restart at the start edge, on WAIT_IDLE entry and
   // whenever the line drops low while waiting for a full idle bit.
   assign cnt_clr = (state == S_IDLE)
                 || (state == S_WAIT && !rxs)
                 || (state_nxt == S_WAIT && state != S_WAIT);

   // Two-flop synchroniser for the asynchronous serial line.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx_in;
         rxs     <= rx_meta;
      end
   end

   // Clock divider producing one tick per oversample period.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt <= '0;
      end else if (cnt_clr || tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // Oversample position within the current bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         samp_cnt <= '0;
      end else if (cnt_clr) begin
         samp_cnt <= '0;
      end else if (tick) begin
         samp_cnt <= (samp_cnt == SMP_LAST) ? '0 : samp_cnt + 1'b1;
      end
   end

   // First two of the three mid-bit samples; the third is rxs itself.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s0 <= 1'b1;
         s1 <= 1'b1;
      end else begin
         if (tick && samp_cnt == SMP_A) s0 <= rxs;
         if (tick && samp_cnt == SMP_B) s1 <= rxs;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; completion fires at the last stop decision.
   always_comb begin
      state_nxt = state;
      complete  = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (!rxs) state_nxt = S_START;
         end
         S_START: begin
            if (at_dec && vote) begin
               state_nxt = S_IDLE;
            end else if (at_wrap) begin
               state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (at_wrap && bit_idx == BIT_LAST) begin
               state_nxt = HAS_PAR ? S_PAR : S_STOP;
            end
         end
         S_PAR: begin
            if (at_wrap) state_nxt = S_STOP;
         end
         S_STOP: begin
            if (at_dec && stop_idx == STOP_LAST) begin
               complete  = 1'b1;
               state_nxt = fe_fin ? S_WAIT : S_IDLE;
            end
         end
         S_WAIT: begin
            if (tick && rxs && samp_cnt == SMP_LAST) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Frame assembly: data shift-in, parity check, stop-bit check.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         shreg    <= '0;
         fe_int   <= 1'b0;
         pe_int   <= 1'b0;
      end else if (state == S_IDLE) begin
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         fe_int   <= 1'b0;
         pe_int   <= 1'b0;
      end else begin
         if (state == S_DATA && at_dec) begin
            shreg[bit_idx] <= vote;
         end
         if (state == S_DATA && at_wrap) begin
            bit_idx <= bit_idx + 1'b1;
         end
         if (state == S_PAR && at_dec) begin
            pe_int <= (((^shreg) ^ vote) != PAR_ODD);
         end
         if (state == S_STOP && at_dec && !vote) begin
            fe_int <= 1'b1;
         end
         if (state == S_STOP && at_wrap) begin
            stop_idx <= stop_idx + 1'b1;
         end
      end
   end

   // One-entry output register; a full, stalled register drops the
   // new word and flags an overrun instead.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         frame_err   <= 1'b0;
         parity_err  <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         overrun_err <= 1'b0;
         if (complete) begin
            if (!rx_valid || rx_ready) begin
               rx_data    <= shreg;
               frame_err  <= fe_fin;
               parity_err <= pe_int;
               rx_valid   <= 1'b1;
            end else begin
               overrun_err <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
